// File: rtl/instr_fetch_seq_if.sv
// Fetch-unit bus: run control, combinational ROM port, jump-target LUT write
// port and the registered instruction stream handed to the decoder.
interface instr_fetch_seq_if #(
  parameter int PC_W   = 10,
  parameter int IW     = 9,
  parameter int LUT_AW = 4
);
  logic              Start;
  logic              Stall;
  logic              jump_en;
  logic              branch_take;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   rom_addr;
  logic [IW-1:0]     rom_data;
  logic [IW-1:0]     instr_out;
  logic              instr_valid;
  logic [PC_W-1:0]   pc_out;
  logic              Done;
  logic              pc_wrap_err;

  modport master (
    input  Start, Stall, jump_en, branch_take, lut_we, lut_waddr, lut_wdata, rom_data,
    output rom_addr, instr_out, instr_valid, pc_out, Done, pc_wrap_err
  );

  modport slave (
    output Start, Stall, jump_en, branch_take, lut_we, lut_waddr, lut_wdata, rom_data,
    input  rom_addr, instr_out, instr_valid, pc_out, Done, pc_wrap_err
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// Fetch/sequencer for the 9-bit accumulator ISA: PC, registered instruction,
// jump-target LUT redirects, HALT detection and restart on Start.
module instr_fetch_seq #(
  parameter int         PC_W     = 10,
  parameter int         IW       = 9,
  parameter int         LUT_AW   = 4,
  parameter logic [3:0] HALT_OPC = 4'b1111
) (
  input  logic              Clk,
  input  logic              Reset,
  instr_fetch_seq_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              LUT_N  = 1 << LUT_AW;
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0] PC_MAX = {PC_W{1'b1}};

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [IW-1:0]   r_instr, w_instr_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_done, w_done_nxt;
  logic            r_wrap, w_wrap_nxt;
  logic [PC_W-1:0] r_lut [LUT_N];

  logic [3:0]      w_opcode;
  logic            w_is_halt;
  logic            w_redirect;
  logic [PC_W-1:0] w_target;

  assign w_opcode   = r_instr[IW-1 -: 4];
  assign w_is_halt  = r_valid && (w_opcode == HALT_OPC);
  assign w_redirect = r_valid && (bus.jump_en || bus.branch_take);
  // Read before the same-cycle write lands, so a colliding redirect sees the old entry.
  assign w_target   = r_lut[r_instr[LUT_AW-1:0]];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    w_wrap_nxt  = r_wrap;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_valid_nxt = 1'b0;
        if (bus.Start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = '0;
          w_done_nxt  = 1'b0;
          w_wrap_nxt  = 1'b0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RUN: begin
        if (bus.Stall) begin
          w_state_nxt = S_RUN;
        end else if (w_is_halt) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_valid_nxt = 1'b0;
        end else if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_valid_nxt = 1'b0;
        end else begin
          w_instr_nxt = bus.rom_data;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = r_pc + PC_ONE;
          w_wrap_nxt  = r_wrap | (r_pc == PC_MAX);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LUT_N; i++) begin
        r_lut[i] <= '0;
      end
    end else if (bus.lut_we) begin
      r_lut[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  assign bus.rom_addr    = r_pc;
  assign bus.pc_out      = r_pc;
  assign bus.instr_out   = r_instr;
  assign bus.instr_valid = r_valid;
  assign bus.Done        = r_done;
  assign bus.pc_wrap_err = r_wrap;
endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench: directed program scenarios plus randomized control traffic
// against a behavioural fetch model; a PC_W=4 instance covers PC wrap.
module tb_instr_fetch_seq;
  localparam int PC_W   = 10;
  localparam int IW     = 9;
  localparam int LUT_AW = 4;
  localparam int SPC_W  = 4;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_fetch_seq_if #(.PC_W(PC_W),  .IW(IW), .LUT_AW(LUT_AW)) bus_m ();
  instr_fetch_seq_if #(.PC_W(SPC_W), .IW(IW), .LUT_AW(LUT_AW)) bus_s ();

  logic [IW-1:0] rom   [0:(1<<PC_W)-1];
  logic [IW-1:0] rom_s [0:(1<<SPC_W)-1];

  assign bus_m.rom_data = rom[bus_m.rom_addr];
  assign bus_s.rom_data = rom_s[bus_s.rom_addr];

  instr_fetch_seq #(.PC_W(PC_W), .IW(IW), .LUT_AW(LUT_AW), .HALT_OPC(OP_HALT)) u_dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus_m)
  );

  instr_fetch_seq #(.PC_W(SPC_W), .IW(IW), .LUT_AW(LUT_AW), .HALT_OPC(OP_HALT)) u_dut_s (
    .Clk   (clk),
    .Reset (rst_s),
    .bus   (bus_s)
  );

  // Reference model: a running/halted program with a PC, a fetched word and a target table.
  bit              m_run;
  bit              m_done;
  bit              m_valid;
  bit              m_wrap;
  logic [PC_W-1:0] m_pc;
  logic [IW-1:0]   m_instr;
  logic [PC_W-1:0] m_lut [0:(1<<LUT_AW)-1];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic [PC_W-1:0] tgt;
    if (rst) begin
      m_run = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_wrap = 1'b0;
      m_pc = '0; m_instr = '0;
      for (int i = 0; i < (1<<LUT_AW); i++) m_lut[i] = '0;
    end else begin
      tgt = m_lut[m_instr[LUT_AW-1:0]];
      if (!m_run) begin
        if (bus_m.Start) begin
          m_run = 1'b1; m_done = 1'b0; m_valid = 1'b0; m_wrap = 1'b0; m_pc = '0;
        end
      end else if (!bus_m.Stall) begin
        if (m_valid && m_instr[IW-1:IW-4] == OP_HALT) begin
          m_run = 1'b0; m_done = 1'b1; m_valid = 1'b0;
        end else if (m_valid && (bus_m.jump_en || bus_m.branch_take)) begin
          m_pc = tgt; m_valid = 1'b0;
        end else begin
          m_instr = rom[m_pc];
          m_valid = 1'b1;
          if (int'(m_pc) == (1<<PC_W) - 1) m_wrap = 1'b1;
          m_pc = PC_W'((int'(m_pc) + 1) % (1<<PC_W));
        end
      end
      if (bus_m.lut_we) m_lut[bus_m.lut_waddr] = bus_m.lut_wdata;
    end
  endtask

  task automatic compare_all();
    check_val("pc",       32'(bus_m.pc_out),      32'(m_pc));
    check_val("rom_addr", 32'(bus_m.rom_addr),    32'(m_pc));
    check_val("instr",    32'(bus_m.instr_out),   32'(m_instr));
    check_val("valid",    32'(bus_m.instr_valid), 32'(m_valid));
    check_val("done",     32'(bus_m.Done),        32'(m_done));
    check_val("wrap",     32'(bus_m.pc_wrap_err), 32'(m_wrap));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    bus_m.Start = 1'b0; bus_m.Stall = 1'b0; bus_m.jump_en = 1'b0; bus_m.branch_take = 1'b0;
    bus_m.lut_we = 1'b0; bus_m.lut_waddr = '0; bus_m.lut_wdata = '0;
  endtask

  initial begin
    idle_inputs();
    bus_s.Start = 1'b0; bus_s.Stall = 1'b0; bus_s.jump_en = 1'b0; bus_s.branch_take = 1'b0;
    bus_s.lut_we = 1'b0; bus_s.lut_waddr = '0; bus_s.lut_wdata = '0;
    rst = 1'b1;
    rst_s = 1'b1;
    for (int i = 0; i < (1<<PC_W); i++) rom[i] = {4'($urandom_range(0, 14)), 5'($urandom)};
    for (int i = 0; i < (1<<SPC_W); i++) rom_s[i] = {OP_ADD, 5'd0};
    @(negedge clk);
    tick();
    tick();
    check_val("rst_pc", 32'(bus_m.pc_out), 32'd0);
    check_val("rst_valid", 32'(bus_m.instr_valid), 32'd0);
    check_val("rst_instr", 32'(bus_m.instr_out), 32'd0);
    rst = 1'b0;

    // Straight-line program ending in HALT.
    rom[0] = {OP_ADD, 5'd1}; rom[1] = {OP_SUB, 5'd2}; rom[2] = {OP_AND, 5'd3}; rom[3] = {OP_HALT, 5'd0};
    bus_m.Start = 1'b1; tick(); bus_m.Start = 1'b0;
    check_val("lat1_valid", 32'(bus_m.instr_valid), 32'd0);
    tick();
    check_val("lat2_valid", 32'(bus_m.instr_valid), 32'd1);
    check_val("lat2_instr", 32'(bus_m.instr_out), 32'h001);
    check_val("lat2_pc", 32'(bus_m.pc_out), 32'd1);
    tick(); tick(); tick();
    check_val("halt_pc", 32'(bus_m.pc_out), 32'd4);
    check_val("halt_instr", 32'(bus_m.instr_out), 32'h1E0);
    tick();
    check_val("done_set", 32'(bus_m.Done), 32'd1);
    check_val("done_valid", 32'(bus_m.instr_valid), 32'd0);

    // Unconditional jump through lut[5].
    bus_m.lut_we = 1'b1; bus_m.lut_waddr = 4'd5; bus_m.lut_wdata = 10'h020; tick(); bus_m.lut_we = 1'b0;
    rom[2] = {OP_JMP, 5'd5}; rom[3] = {OP_ADD, 5'd4}; rom[32] = {OP_SUB, 5'h1A};
    bus_m.Start = 1'b1; tick(); bus_m.Start = 1'b0;
    check_val("restart_done", 32'(bus_m.Done), 32'd0);
    tick(); tick(); tick();
    check_val("jmp_instr", 32'(bus_m.instr_out), 32'h105);
    bus_m.jump_en = 1'b1; tick(); bus_m.jump_en = 1'b0;
    check_val("jmp_bubble", 32'(bus_m.instr_valid), 32'd0);
    check_val("jmp_pc", 32'(bus_m.pc_out), 32'h020);
    tick();
    check_val("jmp_tgt_instr", 32'(bus_m.instr_out), 32'h03A);
    check_val("jmp_tgt_pc", 32'(bus_m.pc_out), 32'h021);
    bus_m.Start = 1'b1; tick(); bus_m.Start = 1'b0;
    check_val("start_in_run", 32'(bus_m.pc_out), 32'h022);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check_val("mid_rst_pc", 32'(bus_m.pc_out), 32'd0);
    check_val("mid_rst_valid", 32'(bus_m.instr_valid), 32'd0);

    // Stall over a valid JMP; LUT was cleared so the redirect lands on 0.
    rom[4] = {OP_BNE, 5'd6}; rom[5] = {OP_BNE, 5'd6}; rom[16] = {OP_AND, 5'h11};
    bus_m.Start = 1'b1; tick(); bus_m.Start = 1'b0;
    tick(); tick(); tick();
    bus_m.jump_en = 1'b1; bus_m.Stall = 1'b1;
    bus_m.lut_we = 1'b1; bus_m.lut_waddr = 4'd6; bus_m.lut_wdata = 10'h010;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus_m.lut_we = 1'b0;
      check_val("stall_pc", 32'(bus_m.pc_out), 32'd3);
      check_val("stall_instr", 32'(bus_m.instr_out), 32'h105);
    end
    bus_m.Stall = 1'b0; tick(); bus_m.jump_en = 1'b0;
    check_val("unstall_pc", 32'(bus_m.pc_out), 32'd0);
    check_val("unstall_valid", 32'(bus_m.instr_valid), 32'd0);
    tick(); tick(); tick(); tick(); tick();
    check_val("bne_instr", 32'(bus_m.instr_out), 32'h126);
    tick();
    check_val("bne_nt_pc", 32'(bus_m.pc_out), 32'd6);
    check_val("bne_nt_valid", 32'(bus_m.instr_valid), 32'd1);
    bus_m.branch_take = 1'b1; tick(); bus_m.branch_take = 1'b0;
    check_val("bne_t_pc", 32'(bus_m.pc_out), 32'h010);
    tick();
    check_val("bne_t_instr", 32'(bus_m.instr_out), 32'h051);

    // Randomized control traffic over a random program with occasional HALTs.
    for (int i = 0; i < (1<<PC_W); i++) begin
      rom[i] = {($urandom_range(0, 31) == 0) ? OP_HALT : 4'($urandom_range(0, 14)), 5'($urandom)};
    end
    for (int c = 0; c < 3000; c++) begin
      rst               = ($urandom_range(0, 199) == 0);
      bus_m.Start       = ($urandom_range(0, 3) == 0);
      bus_m.Stall       = ($urandom_range(0, 4) == 0);
      bus_m.jump_en     = ($urandom_range(0, 7) == 0);
      bus_m.branch_take = ($urandom_range(0, 7) == 0);
      bus_m.lut_we      = ($urandom_range(0, 3) == 0);
      bus_m.lut_waddr   = 4'($urandom);
      bus_m.lut_wdata   = 10'($urandom);
      tick();
    end
    rst = 1'b0;
    idle_inputs();

    // PC_W=4 instance: wrap 15->0 sets a sticky error cleared only by Start.
    tick();
    rst_s = 1'b0;
    bus_s.Start = 1'b1; tick(); bus_s.Start = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    check_val("s_pc15", 32'(bus_s.pc_out), 32'd15);
    check_val("s_nowrap", 32'(bus_s.pc_wrap_err), 32'd0);
    tick();
    check_val("s_pc0", 32'(bus_s.pc_out), 32'd0);
    check_val("s_wrap", 32'(bus_s.pc_wrap_err), 32'd1);
    rom_s[2] = {OP_HALT, 5'd0};
    bus_s.Start = 1'b1;
    tick(); tick(); tick(); tick();
    check_val("s_done", 32'(bus_s.Done), 32'd1);
    check_val("s_wrap_sticky", 32'(bus_s.pc_wrap_err), 32'd1);
    tick();
    bus_s.Start = 1'b0;
    check_val("s_wrap_clr", 32'(bus_s.pc_wrap_err), 32'd0);
    check_val("s_restart_pc", 32'(bus_s.pc_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
